// File: rtl/gb_pkg.sv
// Shared Game Boy definitions.
//   DMA_REG_ADDR : CPU address of the OAM DMA source register
//   OAM_BASE     : first OAM byte, destination of every DMA transfer
//   DMA_LEN      : bytes copied per transfer
//   dma_state_t  : OAM DMA sequencer states
package gb_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam int          DMA_LEN      = 160;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } dma_state_t;

endpackage

// File: rtl/dma_controller.sv
// OAM DMA controller. A CPU write to the source register copies LEN bytes
// from {src_hi, 8'h00} upward into OAM, one READ and one WRITE bus cycle per
// byte, after a single START cycle.
// Ports:
//   clock, reset         : system clock, async active-high reset
//   cs, A, Di, Do,
//   rd_n, wr_n           : CPU register access (Do is the source high byte)
//   A_dma, Di_dma,
//   Do_dma, rd_dma_n,
//   wr_dma_n             : bus-master side used while transferring
//   busy                 : transfer in progress (bus granted to DMA)
module dma_controller
    import gb_pkg::*;
#(
    parameter int LEN = DMA_LEN
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cs,
    input  logic [15:0] A,
    input  logic [7:0]  Di,
    output logic [7:0]  Do,
    input  logic        rd_n,
    input  logic        wr_n,
    output logic [15:0] A_dma,
    input  logic [7:0]  Di_dma,
    output logic [7:0]  Do_dma,
    output logic        rd_dma_n,
    output logic        wr_dma_n,
    output logic        busy
);

    localparam logic [8:0] LEN_W = 9'(LEN);

    dma_state_t state_q, state_d;
    logic [7:0] src_q, src_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] buf_q, buf_d;

    logic       reg_wr;
    logic [8:0] idx_inc;

    assign reg_wr  = cs && !wr_n && (A == DMA_REG_ADDR);
    // One bit wider so the end-of-transfer compare cannot wrap.
    assign idx_inc = {1'b0, idx_q} + 9'd1;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= 8'h00;
            idx_q   <= 8'h00;
            buf_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        case (state_q)
            START: state_d = READ;
            READ: begin
                buf_d   = Di_dma;
                state_d = WRITE;
            end
            WRITE: begin
                idx_d   = idx_inc[7:0];
                state_d = (idx_inc < LEN_W) ? READ : IDLE;
            end
            default: ;
        endcase
        // A register write always (re)starts from byte 0, overriding any
        // transfer in flight, including its final WRITE cycle.
        if (reg_wr) begin
            src_d   = Di;
            idx_d   = 8'h00;
            state_d = START;
        end
    end

    // Outputs (decoded from state only, so reset quiets the bus at once)
    always_comb begin
        A_dma    = 16'h0000;
        Do_dma   = 8'h00;
        rd_dma_n = 1'b1;
        wr_dma_n = 1'b1;
        case (state_q)
            READ: begin
                A_dma    = {src_q, idx_q};
                rd_dma_n = 1'b0;
            end
            WRITE: begin
                A_dma    = OAM_BASE + {8'h00, idx_q};
                Do_dma   = buf_q;
                wr_dma_n = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign Do   = (cs && !rd_n) ? src_q : 8'h00;

endmodule

// File: tb/tb_dma_controller.sv
module tb_dma_controller;
    import gb_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0, rd_n = 1'b1, wr_n = 1'b1;
    logic [15:0] A = 16'h0000;
    logic [7:0]  Di = 8'h00;
    logic [7:0]  Do, Di_dma, Do_dma;
    logic [15:0] A_dma;
    logic        rd_dma_n, wr_dma_n, busy;

    always #5 clock = ~clock;

    dma_controller #(.LEN(160)) dut (
        .clock(clock), .reset(reset), .cs(cs), .A(A), .Di(Di), .Do(Do),
        .rd_n(rd_n), .wr_n(wr_n), .A_dma(A_dma), .Di_dma(Di_dma),
        .Do_dma(Do_dma), .rd_dma_n(rd_dma_n), .wr_dma_n(wr_dma_n), .busy(busy)
    );

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } bus_ev_t;

    bus_ev_t exp_q[$];
    int      exp_busy[$];
    int      checks = 0;
    int      errors = 0;
    int      busy_run = 0;
    bus_ev_t mon_e;
    logic [7:0] oam [0:255];

    // Source memory contents seen by the DMA master.
    function automatic logic [7:0] memval(input logic [7:0] hi, input logic [7:0] lo);
        case (hi)
            8'hC1:   return lo;
            8'hD0:   return lo ^ 8'h5A;
            default: return lo + hi;
        endcase
    endfunction

    assign Di_dma = !rd_dma_n ? memval(A_dma[15:8], A_dma[7:0]) : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic push_rw(input logic [7:0] hi, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            exp_q.push_back({1'b0, hi, 8'(i), memval(hi, 8'(i))});
            exp_q.push_back({1'b1, 16'hFE00 + 16'(i), memval(hi, 8'(i))});
        end
    endtask

    task automatic push_r(input logic [7:0] hi, input int i);
        exp_q.push_back({1'b0, hi, 8'(i), memval(hi, 8'(i))});
    endtask

    // Caller sits on a negedge; the write is sampled on the next posedge.
    task automatic reg_write(input logic [7:0] v);
        cs = 1'b1; wr_n = 1'b0; A = 16'hFF46; Di = v;
        @(negedge clock);
        cs = 1'b0; wr_n = 1'b1; A = 16'h0000; Di = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        bit done = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!busy) begin
                done = 1;
                break;
            end
            @(negedge clock);
        end
        if (!done) chk(name, 32'(busy), 32'd0);
    endtask

    // Monitor: pops expected bus cycles and busy lengths as the DUT shows them.
    always @(negedge clock) begin
        chk("strobe_excl", 32'(!rd_dma_n && !wr_dma_n), 32'd0);
        chk("oam_range", 32'(A_dma >= 16'hFEA0 && A_dma <= 16'hFEFF), 32'd0);
        if (!rd_dma_n || !wr_dma_n) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {A_dma, 14'd0, rd_dma_n, wr_dma_n}, 32'd3);
            end else begin
                mon_e = exp_q.pop_front();
                chk("bus_kind", 32'(!wr_dma_n), 32'(mon_e.wr));
                chk("bus_addr", 32'(A_dma), 32'(mon_e.addr));
                if (mon_e.wr) begin
                    chk("bus_data", 32'(Do_dma), 32'(mon_e.data));
                    oam[A_dma[7:0]] = Do_dma;
                end
            end
        end else begin
            chk("quiet_addr", 32'(A_dma), 32'd0);
            chk("quiet_data", 32'(Do_dma), 32'd0);
        end
        if (busy) begin
            busy_run++;
        end else if (busy_run != 0) begin
            if (exp_busy.size() == 0) chk("unexpected_busy", 32'(busy_run), 32'd0);
            else                      chk("busy_len", 32'(busy_run), 32'(exp_busy.pop_front()));
            busy_run = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clock);
        cs = 1'b1; rd_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd", 32'(rd_dma_n), 32'd1);
        chk("rst_wr", 32'(wr_dma_n), 32'd1);
        chk("rst_Do", 32'(Do), 32'd0);
        cs = 1'b0; rd_n = 1'b1;
        reset = 1'b0;
        @(negedge clock);

        // Register readback while a 0x80 transfer runs
        push_rw(8'h80, 0, 159);
        exp_busy.push_back(321);
        reg_write(8'h80);
        cs = 1'b1; rd_n = 1'b0; #1;
        chk("rd_Do", 32'(Do), 32'h80);
        cs = 1'b0; #1;
        chk("rd_Do_nocs", 32'(Do), 32'h00);
        cs = 1'b1; rd_n = 1'b1; #1;
        chk("rd_Do_nord", 32'(Do), 32'h00);
        cs = 1'b0;
        wait_idle("idle_80");

        // Full transfer from 0xC100
        @(negedge clock);
        push_rw(8'hC1, 0, 159);
        exp_busy.push_back(321);
        reg_write(8'hC1);
        wait_idle("idle_C1");
        chk("oam_C1_0", 32'(oam[0]), 32'h00);
        chk("oam_C1_159", 32'(oam[159]), 32'h9F);

        // Restart 50 clocks in: cut during READ of byte 24
        @(negedge clock);
        push_rw(8'hC0, 0, 23);
        push_r(8'hC0, 24);
        push_rw(8'hD0, 0, 159);
        exp_busy.push_back(371);
        reg_write(8'hC0);
        repeat (49) @(negedge clock);
        reg_write(8'hD0);
        wait_idle("idle_D0");
        chk("oam_D0_0", 32'(oam[0]), 32'h5A);
        chk("oam_D0_24", 32'(oam[24]), 32'h42);
        chk("oam_D0_159", 32'(oam[159]), 32'hC5);

        // Restart written during the final WRITE
        @(negedge clock);
        push_rw(8'hC1, 0, 159);
        push_rw(8'h90, 0, 159);
        exp_busy.push_back(642);
        reg_write(8'hC1);
        repeat (320) @(negedge clock);
        chk("last_wr_addr", 32'(A_dma), 32'hFE9F);
        chk("last_wr_strobe", 32'(wr_dma_n), 32'd0);
        reg_write(8'h90);
        #1;
        chk("rs_start_busy", 32'(busy), 32'd1);
        chk("rs_start_quiet", {30'd0, rd_dma_n, wr_dma_n}, 32'd3);
        @(negedge clock);
        chk("rs_read_strobe", 32'(rd_dma_n), 32'd0);
        chk("rs_read_addr", 32'(A_dma), 32'h9000);
        wait_idle("idle_90");

        // Reset at clock 100 of a transfer
        @(negedge clock);
        push_rw(8'hC1, 0, 48);
        push_r(8'hC1, 49);
        exp_busy.push_back(100);
        reg_write(8'hC1);
        repeat (99) @(negedge clock);
        #1 reset = 1'b1;
        cs = 1'b1; rd_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_strobes", {30'd0, rd_dma_n, wr_dma_n}, 32'd3);
        chk("abort_addr", 32'(A_dma), 32'd0);
        chk("abort_Do", 32'(Do), 32'd0);
        cs = 1'b0; rd_n = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (500) @(negedge clock);

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("exp_busy_empty", 32'(exp_busy.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
